// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-serial RAM arbiter.
package mem_arbiter_pkg;

   // Controller state: idle, instruction fetch, load, store.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_IF   = 2'd1,
      ST_LD   = 2'd2,
      ST_ST   = 2'd3
   } arb_state_t;

   // Which requester received the most recent grant.
   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_LS = 1'b1
   } grant_t;

   // Access size encodings used by the load/store buffer (2'b11 behaves as a word).
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   // addr[17:16] value that selects the memory-mapped I/O region.
   localparam logic [1:0] IO_REGION = 2'b11;

   // True when addr[17:16] points into the I/O region.
   function automatic logic is_io_region(input logic [1:0] region);
      return region == IO_REGION;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial RAM controller shared by the instruction cache and the
// load/store buffer. One access runs at a time; each byte takes one cycle.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic [31:0] data_addr,
   output logic        data_wr,
   input  logic        io_buffer_full,
   input  logic        flush,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_done,
   output logic [31:0] inst_data,
   input  logic        ls_req,
   input  logic        ls_wr,
   input  logic [1:0]  ls_size,
   input  logic        ls_signed,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata
);

   // Index of the final byte of an access of the given size.
   function automatic logic [1:0] f_last_idx(input logic [1:0] size);
      case (size)
         SZ_B:    return 2'd0;
         SZ_H:    return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   // Sign- or zero-extend the low bytes of an assembled load word.
   function automatic logic [31:0] f_extend(input logic [31:0] word,
                                            input logic [1:0]  size,
                                            input logic        sgn);
      logic [31:0] res;
      case (size)
         SZ_B:    res = {{24{sgn & word[7]}}, word[7:0]};
         SZ_H:    res = {{16{sgn & word[15]}}, word[15:0]};
         default: res = word;
      endcase
      return res;
   endfunction

   arb_state_t  r_state;
   grant_t      r_last_grant;
   logic [1:0]  r_idx;
   logic [1:0]  r_last;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [31:0] r_wdata;
   logic [31:0] r_buf;
   logic [31:0] r_data_addr;
   logic [7:0]  r_data_out;
   logic        r_data_wr;
   logic        r_inst_done;
   logic        r_ls_done;
   logic [31:0] r_inst_data;
   logic [31:0] r_ls_rdata;

   logic [1:0]  w_idx_inc;
   logic [7:0]  w_st_byte;
   logic [31:0] w_rd_word;
   logic        w_ls_st_blocked;
   logic        w_if_cand;
   logic        w_ls_cand;
   logic        w_grant_ls;
   logic        w_grant_if;

   assign w_idx_inc = r_idx + 2'd1;
   // Next store byte comes from the lane after the one currently on the bus.
   assign w_st_byte = r_wdata[{w_idx_inc, 3'b000} +: 8];

   // Assembled read word with the byte arriving this cycle merged into lane idx.
   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_rd_word[gi*8 +: 8] = (r_idx == 2'(gi)) ? data_in : r_buf[gi*8 +: 8];
   end

   // A store into the I/O region waits while the UART buffer is full.
   assign w_ls_st_blocked = ls_wr & is_io_region(ls_addr[17:16]) & io_buffer_full;
   // A requester whose completion pulse is showing is still holding its old request.
   assign w_if_cand  = inst_req & ~r_inst_done;
   assign w_ls_cand  = ls_req & ~r_ls_done & ~w_ls_st_blocked;
   // On a tie the side that did not win last time goes first.
   assign w_grant_ls = w_ls_cand & (~w_if_cand | (r_last_grant == GNT_IF));
   assign w_grant_if = w_if_cand & ~w_grant_ls;

   // Arbitration and byte sequencing; everything freezes while rdy is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_last_grant <= GNT_IF;
         r_idx        <= 2'd0;
         r_last       <= 2'd0;
         r_size       <= 2'd0;
         r_signed     <= 1'b0;
         r_wdata      <= 32'd0;
         r_buf        <= 32'd0;
         r_data_addr  <= 32'd0;
         r_data_out   <= 8'd0;
         r_data_wr    <= 1'b0;
         r_inst_done  <= 1'b0;
         r_ls_done    <= 1'b0;
         r_inst_data  <= 32'd0;
         r_ls_rdata   <= 32'd0;
      end else if (rdy) begin
         r_inst_done <= 1'b0;
         r_ls_done   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!flush) begin
                  if (w_grant_ls) begin
                     r_last_grant <= GNT_LS;
                     r_idx        <= 2'd0;
                     r_last       <= f_last_idx(ls_size);
                     r_size       <= ls_size;
                     r_signed     <= ls_signed;
                     r_wdata      <= ls_wdata;
                     r_data_addr  <= ls_addr;
                     if (ls_wr) begin
                        r_state    <= ST_ST;
                        r_data_out <= ls_wdata[7:0];
                        r_data_wr  <= 1'b1;
                     end else begin
                        r_state    <= ST_LD;
                     end
                  end else if (w_grant_if) begin
                     r_last_grant <= GNT_IF;
                     r_idx        <= 2'd0;
                     r_last       <= 2'd3;
                     r_data_addr  <= inst_addr;
                     r_state      <= ST_IF;
                  end
               end
            end
            ST_IF, ST_LD: begin
               if (flush) begin
                  // Speculative read abandoned; no completion is reported.
                  r_state <= ST_IDLE;
               end else begin
                  r_buf <= w_rd_word;
                  if (r_idx == r_last) begin
                     r_state <= ST_IDLE;
                     if (r_state == ST_IF) begin
                        r_inst_done <= 1'b1;
                        r_inst_data <= w_rd_word;
                     end else begin
                        r_ls_done  <= 1'b1;
                        r_ls_rdata <= f_extend(w_rd_word, r_size, r_signed);
                     end
                  end else begin
                     r_idx       <= w_idx_inc;
                     r_data_addr <= r_data_addr + 32'd1;
                  end
               end
            end
            ST_ST: begin
               // Stores are committed and always run to completion, flush or not.
               if (r_idx == r_last) begin
                  r_data_wr <= 1'b0;
                  r_state   <= ST_IDLE;
                  r_ls_done <= 1'b1;
               end else begin
                  r_idx       <= w_idx_inc;
                  r_data_addr <= r_data_addr + 32'd1;
                  r_data_out  <= w_st_byte;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // While frozen, the held store byte and done pulses are masked so nothing
   // is committed twice; they reappear once rdy returns.
   assign data_wr   = r_data_wr & rdy;
   assign inst_done = r_inst_done & rdy;
   assign ls_done   = r_ls_done & rdy;
   assign data_out  = r_data_out;
   assign data_addr = r_data_addr;
   assign inst_data = r_inst_data;
   assign ls_rdata  = r_ls_rdata;

endmodule
